sysu_clk_div_ctrl: RTL
======================

Name: sysu_clk_div_ctrl

Overview:
Run/stop controller and divide-ratio scheduler for the board's clock-divider path. It generates a single-cycle tick enable and a 50%-duty divided clock from the 50 MHz board clock. The divide ratio is reconfigurable at runtime through a valid/ready handshake, with new ratios applied only on period boundaries. It sits between the top-level control logic (switches/FSMs) and every downstream block that consumes a slow enable or slow clock.

Parameters:
W, 32, width of the divide-ratio register and half-period counter
DEF_DIV, 25000000, half-period length in clk_in cycles after reset (1 Hz clk_out at 50 MHz)

Ports:
clk_in  input  1  system clock (50 MHz); all logic on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on clk_in rising edge
en  input  1  run request; 1 = generate ticks/clk_out, 0 = request stop
cfg_valid  input  1  new divide ratio offered on cfg_div
cfg_div  input  W  requested half-period in clk_in cycles; 0 treated as 1
cfg_ready  output  1  controller can accept a new ratio
tick  output  1  one-cycle pulse at end of every half-period
clk_out  output  1  divided clock, toggles on each tick
running  output  1  high in RUN and STOP_WAIT states
div_cur  output  W  ratio currently in effect

Behaviour:
- Reset (rst_n=0 at a clk_in edge): state=IDLE, cnt=0, clk_out=0, tick=0, pending=0, cfg_ready=1, div_cur=DEF_DIV, running=0.
- Effective ratio D = (div_cur==0) ? 1 : div_cur. Zero is also saturated to 1 on load, so div_cur never reads 0.
- States:
  - IDLE: cnt held at 0, clk_out=0, tick=0. If en=1, go to RUN next cycle with cnt=0.
  - RUN: cnt increments each cycle. When cnt==D-1: tick=1 for that cycle (combinational from registered cnt), cnt wraps to 0, and clk_out toggles on the same edge. If en=0 and clk_out=0, go to IDLE. If en=0 and clk_out=1, go to STOP_WAIT.
  - STOP_WAIT: counting continues. At the next tick clk_out toggles to 0 and the state goes to IDLE, so no high runt pulse is produced. If en returns to 1 in STOP_WAIT, go back to RUN with no counter disturbance.
- Tick latency: the first tick occurs D cycles after entering RUN. Period of clk_out is 2*D cycles.
- Config handshake:
  - cfg_ready = ~pending.
  - Transfer occurs when cfg_valid && cfg_ready. On transfer, cfg_div (saturated to 1 if 0) goes into the shadow register and pending=1.
  - In IDLE, a pending shadow is applied on the next cycle: div_cur updates and pending clears.
  - In RUN/STOP_WAIT, the shadow is applied on the tick edge (the cnt wrap), so the next half-period uses the new D and pending clears. A transfer in the same cycle as a tick is applied at the following tick, not the current one.
  - cfg_valid while cfg_ready=0 is ignored. The source must hold it.
- Counter width is W. With D ≤ 2^W-1 there is no overflow. cnt compare uses the effective D.
- Ratio shrink: if the new D takes effect at a wrap, cnt=0 already, so no stale-count hazard exists.
- en and cfg activity in the same cycle are independent. A rising en with a pending shadow in IDLE: the shadow is applied and RUN is entered on the same edge.
- Reset mid-operation: returns immediately to the reset values on the next edge. A pending config is discarded.

Decomposition:
- Package sysu_clk_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, STOP_WAIT=2'd2), board clock frequency constant CLK_HZ=50000000, and a helper constant for the 1 Hz half-period.
- One natural sub-module: sysu_half_period_cnt. It holds the W-bit counter with clear, enable, compare against D, and wrap/tick output. The controller FSM and shadow logic stay in the top.

Test Plan:
- Reset with DEF_DIV overridden to 4, en=1 → first tick 4 cycles after RUN entry, clk_out period 8 cycles, 50% duty, running=1.
- RUN with D=4, cfg_div=2 transferred mid half-period → current half-period still 4 cycles; following half-periods 2 cycles; cfg_ready low until applied; div_cur=2 after the tick.
- cfg_div=0 → div_cur=1, tick every cycle, clk_out toggles every cycle.
- en drops while clk_out=1 (D=4) → STOP_WAIT, clk_out falls at the next tick then IDLE, no further ticks; en drop while clk_out=0 → IDLE next cycle.
- Second cfg_valid while pending=1 → ignored (cfg_ready=0); held request accepted the cycle after the first is applied.
- rst_n=0 asserted for one cycle in RUN with a pending config → next cycle clk_out=0, cnt=0, div_cur=DEF_DIV, cfg_ready=1.

Source files
------------

// File: rtl/sysu_clk_pkg.sv
// Shared constants and state encoding for the board clock-divider controller.
package sysu_clk_pkg;

  localparam int unsigned CLK_HZ          = 50000000;
  localparam int unsigned HALF_PERIOD_1HZ = CLK_HZ / 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sysu_clk_div_ctrl_if.sv
// Control/config/status bundle between the top-level control logic and the divider.
interface sysu_clk_div_ctrl_if #(
  parameter int unsigned W = 32
) ();

  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         tick;
  logic         clk_out;
  logic         running;
  logic [W-1:0] div_cur;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, tick, clk_out, running, div_cur
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, tick, clk_out, running, div_cur
  );

endinterface

// File: rtl/sysu_half_period_cnt.sv
// Half-period counter: counts 0..d-1 while enabled and flags the wrap cycle.
module sysu_half_period_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic         wrap_c
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_c = en && (cnt_q == d - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap_c ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sysu_clk_div_ctrl.sv
// Run/stop FSM and shadowed divide-ratio scheduler producing tick and a 50% clk_out.
module sysu_clk_div_ctrl
  import sysu_clk_pkg::*;
#(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  DEF_DIV = W'(HALF_PERIOD_1HZ)
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  sysu_clk_div_ctrl_if.slave   bus
);

  state_e       state_q, state_d;
  logic         pending_q, pending_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] div_cur_q, div_cur_d;
  logic         clk_out_q, clk_out_d;
  logic         running_q, running_d;
  logic         cfg_ready_q, cfg_ready_d;
  logic         cnt_clr, cnt_en;
  logic         tick_c;
  logic [W-1:0] div_eff;
  logic [W-1:0] cfg_div_sat;

  assign div_eff     = (div_cur_q == '0) ? W'(1) : div_cur_q;
  assign cfg_div_sat = (bus.cfg_div == '0) ? W'(1) : bus.cfg_div;

  sysu_half_period_cnt #(.W(W)) u_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .d      (div_eff),
    .wrap_c (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    div_cur_d = div_cur_q;
    clk_out_d = clk_out_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr   = 1'b1;
        clk_out_d = 1'b0;
        if (bus.en) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (tick_c) clk_out_d = ~clk_out_q;
        // Stop decision looks at the level clk_out will hold after this edge
        if (!bus.en) begin
          if (clk_out_d) begin
            state_d = ST_STOP_WAIT;
          end else begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_STOP_WAIT: begin
        cnt_en = 1'b1;
        if (tick_c) clk_out_d = ~clk_out_q;
        if (bus.en) begin
          state_d = ST_RUN;
        end else if (tick_c) begin
          state_d   = ST_IDLE;
          clk_out_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_clr   = 1'b1;
        clk_out_d = 1'b0;
      end
    endcase

    // Shadow applies only on a period boundary; a new transfer needs an empty shadow
    if (pending_q && ((state_q == ST_IDLE) || tick_c)) begin
      div_cur_d = shadow_q;
      pending_d = 1'b0;
    end else if (bus.cfg_valid && !pending_q) begin
      shadow_d  = cfg_div_sat;
      pending_d = 1'b1;
    end

    running_d   = (state_d != ST_IDLE);
    cfg_ready_d = ~pending_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      div_cur_q   <= DEF_DIV;
      clk_out_q   <= 1'b0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      div_cur_q   <= div_cur_d;
      clk_out_q   <= clk_out_d;
      running_q   <= running_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.tick      = tick_c;
  assign bus.clk_out   = clk_out_q;
  assign bus.running   = running_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.div_cur   = div_cur_q;

endmodule
